// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back.
// Optional MC_ILLEGAL_TRAP_EN makes illegal opcodes a sticky terminal trap; otherwise they retire as NOPs.
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_zero,
  output logic [1:0]          pc_source,
  output logic [3:0]          alu_op,
  output logic [RETIRE_W-1:0] retired,
  output logic                trap
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100, ALU_OR  = 4'b0101, ALU_XOR = 4'b0110, ALU_NOR = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
    S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic logic r_funct_ok(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h26:   return ALU_XOR;
      6'h27:   return ALU_NOR;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Moore outputs for a state; the IR is stable from DECODE on, so opcode/funct are valid here.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = r_alu_op(fn); end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin c.alu_op = ALU_AND; c.ext_zero = 1'b1; end
          OP_ORI:  begin c.alu_op = ALU_OR;  c.ext_zero = 1'b1; end
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB:     c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_source = 2'b01; end
      S_JUMP:     c.pc_source = 2'b10;
      default:    ;
    endcase
    return c;
  endfunction

  state_t              state_reg, state_next;
  ctrl_t               ctrl_reg;
  logic                retire;
  logic [RETIRE_W-1:0] retired_reg;

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             state_next = S_MEM_ADDR;
          OP_RTYPE:                 state_next = r_funct_ok(funct) ? S_EXEC_R : S_ILLEGAL;
          OP_BEQ, OP_BNE:           state_next = S_BRANCH;
          OP_J:                     state_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
          default:                  state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) begin state_next = S_FETCH; retire = 1'b1; end
      S_EXEC_R:   state_next = S_R_WB;
      S_EXEC_I:   state_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        state_next = S_ILLEGAL;
`else
        state_next = S_FETCH;
        retire     = 1'b1;
`endif
      end
      default:    state_next = S_FETCH;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic trap_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      ctrl_reg    <= ctrl_for(S_FETCH, 6'h00, 6'h00);
      retired_reg <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_for(state_next, opcode, funct);
      if (retire) retired_reg <= retired_reg + RETIRE_W'(1);
`ifdef MC_ILLEGAL_TRAP_EN
      if (state_next == S_ILLEGAL) trap_reg <= 1'b1;
`endif
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign trap = trap_reg;
`else
  assign trap = 1'b0;
`endif

  // Handshake- and flag-dependent strobes are gated by reset so nothing fires while held.
  assign ir_write = rst_n && (state_reg == S_FETCH) && mem_ready;
  assign pc_write = rst_n && (((state_reg == S_FETCH) && mem_ready) ||
                              (state_reg == S_JUMP) ||
                              ((state_reg == S_BRANCH) && ((opcode == OP_BNE) ? ~zero : zero)));

  assign mem_read   = ctrl_reg.mem_read;
  assign mem_write  = ctrl_reg.mem_write;
  assign i_or_d     = ctrl_reg.i_or_d;
  assign reg_write  = ctrl_reg.reg_write;
  assign reg_dst    = ctrl_reg.reg_dst;
  assign mem_to_reg = ctrl_reg.mem_to_reg;
  assign alu_src_a  = ctrl_reg.alu_src_a;
  assign alu_src_b  = ctrl_reg.alu_src_b;
  assign ext_zero   = ctrl_reg.ext_zero;
  assign pc_source  = ctrl_reg.pc_source;
  assign alu_op     = ctrl_reg.alu_op;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues per-cycle expected control words,
// the monitor checks them on the falling edge. Retire counter narrowed to 8 bits to reach wrap.
module tb_multicycle_control;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    opcode = 6'h00;
  logic [5:0]    funct = 6'h00;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic          reg_dst, mem_to_reg, alu_src_a, ext_zero, trap;
  logic [1:0]    alu_src_b, pc_source;
  logic [3:0]    alu_op;
  logic [RW-1:0] retired;

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .pc_source(pc_source), .alu_op(alu_op), .retired(retired),
    .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [18:0]   ctl;
    logic [RW-1:0] ret;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  logic [RW-1:0] ret_exp = '0;

  wire [18:0] act_ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write, reg_dst,
                         mem_to_reg, alu_src_a, alu_src_b, ext_zero, pc_source, alu_op, trap};

  function automatic logic [18:0] mk(input logic mr, mw, iod, irw, pcw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, input logic ez,
                                     input logic [1:0] pcs, input logic [3:0] aop,
                                     input logic t);
    return {mr, mw, iod, irw, pcw, rw, rd, m2r, asa, asb, ez, pcs, aop, t};
  endfunction

  logic [18:0] F_IDLE, F_GO, DEC, MADDR, MRD, MWB, MWR, RWB, IWB, JMP, ILL, ILL_T;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if (act_ctl !== e.ctl || retired !== e.ret) begin
        bad++;
        $display("FAIL %s: ctl=%b retired=%0h, required ctl=%b retired=%0h",
                 e.nm, act_ctl, retired, e.ctl, e.ret);
      end
    end
  end

  task automatic cyc(input string nm, input logic rdy, input logic z, input logic [5:0] op,
                     input logic [5:0] fn, input logic [18:0] c, input logic ret_inc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1; mem_ready = rdy; zero = z; opcode = op; funct = fn;
    e.nm = nm; e.ctl = c; e.ret = ret_exp;
    sb_q.push_back(e);
    if (ret_inc) ret_exp = ret_exp + 1'b1;
  endtask

  task automatic rst_cyc(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    ret_exp = '0;
    e.nm = nm; e.ctl = F_IDLE; e.ret = '0;
    sb_q.push_back(e);
  endtask

  task automatic fd(input string nm, input logic [5:0] op, input logic [5:0] fn);
    cyc({nm, ".fetch"}, 1'b1, 1'b0, op, fn, F_GO, 1'b0);
    cyc({nm, ".decode"}, 1'b1, 1'b0, op, fn, DEC, 1'b0);
  endtask

  function automatic logic [18:0] ex_r(input logic [3:0] aop);
    return mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,aop,0);
  endfunction
  function automatic logic [18:0] ex_i(input logic [3:0] aop, input logic ez);
    return mk(0,0,0,0,0,0,0,0,1,2'b10,ez,2'b00,aop,0);
  endfunction
  function automatic logic [18:0] br(input logic pcw);
    return mk(0,0,0,0,pcw,0,0,0,1,2'b00,0,2'b01,4'b0001,0);
  endfunction

  task automatic do_rtype(input string nm, input logic [5:0] fn, input logic [3:0] aop);
    fd(nm, 6'h00, fn);
    cyc({nm, ".exec"}, 1'b1, 1'b0, 6'h00, fn, ex_r(aop), 1'b0);
    cyc({nm, ".wb"}, 1'b1, 1'b0, 6'h00, fn, RWB, 1'b1);
    $display("instr %s retired=%0h", nm, ret_exp);
  endtask

  task automatic do_itype(input string nm, input logic [5:0] op, input logic [3:0] aop,
                          input logic ez);
    fd(nm, op, 6'h11);
    cyc({nm, ".exec"}, 1'b1, 1'b0, op, 6'h11, ex_i(aop, ez), 1'b0);
    cyc({nm, ".wb"}, 1'b1, 1'b0, op, 6'h11, IWB, 1'b1);
    $display("instr %s retired=%0h", nm, ret_exp);
  endtask

  task automatic do_branch(input string nm, input logic [5:0] op, input logic z,
                           input logic pcw);
    fd(nm, op, 6'h00);
    cyc({nm, ".branch"}, 1'b1, z, op, 6'h00, br(pcw), 1'b1);
    $display("instr %s zero=%0b retired=%0h", nm, z, ret_exp);
  endtask

  task automatic do_jump(input string nm);
    fd(nm, 6'h02, 6'h00);
    cyc({nm, ".jump"}, 1'b1, 1'b0, 6'h02, 6'h00, JMP, 1'b1);
  endtask

  initial begin
    F_IDLE = mk(1,0,0,0,0,0,0,0,0,2'b01,0,2'b00,4'h0,0);
    F_GO   = mk(1,0,0,1,1,0,0,0,0,2'b01,0,2'b00,4'h0,0);
    DEC    = mk(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,4'h0,0);
    MADDR  = mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'h0,0);
    MRD    = mk(1,0,1,0,0,0,0,0,0,2'b00,0,2'b00,4'h0,0);
    MWB    = mk(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,4'h0,0);
    MWR    = mk(0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,4'h0,0);
    RWB    = mk(0,0,0,0,0,1,1,0,0,2'b00,0,2'b00,4'h0,0);
    IWB    = mk(0,0,0,0,0,1,0,0,0,2'b00,0,2'b00,4'h0,0);
    JMP    = mk(0,0,0,0,1,0,0,0,0,2'b00,0,2'b10,4'h0,0);
    ILL    = 19'h0;
    ILL_T  = 19'h1;

    rst_cyc("reset0");
    rst_cyc("reset1");

    // lw: 5 cycles, one stall in FETCH first
    cyc("lw.fetch_stall", 1'b0, 1'b0, 6'h23, 6'h00, F_IDLE, 1'b0);
    fd("lw", 6'h23, 6'h00);
    cyc("lw.addr", 1'b1, 1'b0, 6'h23, 6'h00, MADDR, 1'b0);
    cyc("lw.rd", 1'b1, 1'b0, 6'h23, 6'h00, MRD, 1'b0);
    cyc("lw.wb", 1'b1, 1'b0, 6'h23, 6'h00, MWB, 1'b1);
    $display("instr lw retired=%0h", ret_exp);

    // sw with three stalled MEM_WR cycles: 7 cycles, one retire
    fd("sw", 6'h2B, 6'h00);
    cyc("sw.addr", 1'b1, 1'b0, 6'h2B, 6'h00, MADDR, 1'b0);
    for (int i = 0; i < 3; i++) cyc("sw.wr_stall", 1'b0, 1'b0, 6'h2B, 6'h00, MWR, 1'b0);
    cyc("sw.wr", 1'b1, 1'b0, 6'h2B, 6'h00, MWR, 1'b1);
    $display("instr sw retired=%0h", ret_exp);

    do_rtype("nor", 6'h27, 4'b0111);
    do_rtype("sub", 6'h22, 4'b0001);
    do_rtype("slt", 6'h2A, 4'b0010);
    do_rtype("xor", 6'h26, 4'b0110);
    do_itype("ori", 6'h0D, 4'b0101, 1'b1);
    do_itype("andi", 6'h0C, 4'b0100, 1'b1);
    do_itype("addi", 6'h08, 4'b0000, 1'b0);
    do_branch("beq_taken", 6'h04, 1'b1, 1'b1);
    do_branch("beq_not", 6'h04, 1'b0, 1'b0);
    do_branch("bne_not", 6'h05, 1'b1, 1'b0);
    do_branch("bne_taken", 6'h05, 1'b0, 1'b1);
    do_jump("j");
    $display("instr j retired=%0h", ret_exp);

    // drive the retire counter through all-ones and back to zero
    while (ret_exp != {RW{1'b1}}) do_jump("j_fill");
    $display("instr j_fill reached retired=%0h", ret_exp);
    do_jump("j_wrap");
    cyc("wrap.fetch", 1'b0, 1'b0, 6'h02, 6'h00, F_IDLE, 1'b0);
    $display("instr j_wrap retired=%0h", ret_exp);
    do_jump("j_post");

    // reset asserted while stalled in MEM_RD
    fd("lw_abort", 6'h23, 6'h00);
    cyc("lw_abort.addr", 1'b1, 1'b0, 6'h23, 6'h00, MADDR, 1'b0);
    cyc("lw_abort.rd_stall", 1'b0, 1'b0, 6'h23, 6'h00, MRD, 1'b0);
    rst_cyc("lw_abort.reset");
    cyc("post_reset.fetch_stall", 1'b0, 1'b0, 6'h23, 6'h00, F_IDLE, 1'b0);
    $display("instr lw_abort retired=%0h", ret_exp);

`ifndef MC_ILLEGAL_TRAP_EN
    fd("bad_funct", 6'h00, 6'h00);
    cyc("bad_funct.illegal", 1'b1, 1'b0, 6'h00, 6'h00, ILL, 1'b1);
    $display("instr bad_funct retired=%0h", ret_exp);
    fd("op3f", 6'h3F, 6'h00);
    cyc("op3f.illegal", 1'b1, 1'b0, 6'h3F, 6'h00, ILL, 1'b1);
    $display("instr op3f retired=%0h", ret_exp);
    do_jump("j_after_illegal");
`else
    fd("op3f", 6'h3F, 6'h00);
    cyc("op3f.trap", 1'b1, 1'b0, 6'h3F, 6'h00, ILL_T, 1'b0);
    for (int i = 0; i < 10; i++) cyc("op3f.trap_hold", 1'b1, 1'b1, 6'h3F, 6'h00, ILL_T, 1'b0);
    $display("instr op3f trapped retired=%0h", ret_exp);
    rst_cyc("trap.reset");
    do_jump("j_after_trap");
`endif
    $display("instr final retired=%0h", ret_exp);

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
